// File: rtl/bsg_fsb_node_ls_ctrl_pkg.sv
// Shared definitions for the FSB node level-shift/isolation controller.
//
// Contents:
//   ls_state_e      3-bit FSM state encoding (also exported on state_o)
//   ls_out_s        bundle of the state-decoded control outputs
//   counter_width   bits needed to hold a count of 0..max_val
//   decode_outputs  state -> isolation/reset/quiesce/on levels
package bsg_fsb_node_ls_ctrl_pkg;

  // Encodings are visible on the debug port, so they are pinned explicitly.
  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RESET  = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4
  } ls_state_e;

  typedef struct packed {
    logic en_ls;
    logic node_reset;
    logic quiesce;
    logic on;
  } ls_out_s;

  // A count that must reach max_val needs ceil(log2(max_val+1)) bits.
  // A zero-width counter is never useful, so one bit is the floor.
  function automatic int counter_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // The node is isolated (en_ls=0) in OFF and SETTLE, held in reset everywhere
  // except RUN and DRAIN, and told to quiesce in every state except RUN.
  function automatic ls_out_s decode_outputs(input ls_state_e st);
    ls_out_s o;
    o = '{en_ls: 1'b0, node_reset: 1'b1, quiesce: 1'b1, on: 1'b0};
    case (st)
      ST_RESET: o.en_ls = 1'b1;
      ST_RUN: begin
        o.en_ls      = 1'b1;
        o.node_reset = 1'b0;
        o.quiesce    = 1'b0;
        o.on         = 1'b1;
      end
      ST_DRAIN: begin
        o.en_ls      = 1'b1;
        o.node_reset = 1'b0;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bsg_fsb_node_ls_ctrl_if.sv
// Link between the sequencer and one node's level-shift/isolation wrapper.
//
// Signals (directions named from the sequencer's point of view):
//   pg_i          node power-good, already synchronized
//   fsb_v_i       node->FSB valid, observed after the shifter
//   node_v_i      FSB->node valid, observed after the shifter
//   en_ls_o       level-shifter enable, 0 = isolated
//   node_reset_o  reset into the node domain
//   quiesce_o     ask node and FSB to stop issuing new packets
//
// Modports:
//   master  the sequencer (bsg_fsb_node_ls_ctrl)
//   slave   the wrapper / node side
interface bsg_fsb_node_ls_ctrl_if;

  logic pg_i;
  logic fsb_v_i;
  logic node_v_i;
  logic en_ls_o;
  logic node_reset_o;
  logic quiesce_o;

  modport master (
    input  pg_i, fsb_v_i, node_v_i,
    output en_ls_o, node_reset_o, quiesce_o
  );

  modport slave (
    output pg_i, fsb_v_i, node_v_i,
    input  en_ls_o, node_reset_o, quiesce_o
  );

endinterface

// File: rtl/bsg_fsb_node_ls_ctrl_counter.sv
// bsg_counter_clear_up: synchronous up-counter with clear and enable.
//
// Ports:
//   clk_i    clock
//   reset_i  synchronous active-high reset, count returns to 0
//   clear_i  synchronous clear, wins over up_i
//   up_i     increment enable
//   count_o  current count, width from counter_width(max_val_p)
//
// The count saturates at max_val_p instead of wrapping, so a stuck
// controller can never alias a long wait into a short one.
module bsg_counter_clear_up
  import bsg_fsb_node_ls_ctrl_pkg::*;
#(
  parameter int max_val_p = 8,
  localparam int width_lp = counter_width(max_val_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  localparam logic [width_lp-1:0] MaxVal = width_lp'(max_val_p);

  logic [width_lp-1:0] count_q;

  // Clear and reset share one path; increment only below the ceiling.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      count_q <= '0;
    end else if (up_i && (count_q != MaxVal)) begin
      count_q <= count_q + width_lp'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_fsb_node_ls_ctrl.sv
// bsg_fsb_node_ls_ctrl: power-up / power-down sequencer for one FSB node
// behind its level-shift/isolation wrapper. Lives in the always-on domain.
//
// Ports:
//   clk_i, reset_i  clock and synchronous active-high reset
//   up_req_i        level request to power the node up
//   down_req_i      level request to power the node down
//   link            wrapper link (master side): pg/valid in, en_ls/reset/quiesce out
//   on_o            high only while in RUN
//   timeout_o       one-cycle pulse when DRAIN is ended by its timeout
//   fault_o         sticky, power-good was lost while the shifter was enabled
//   state_o         FSM state encoding, for debug
//
// Sequence: OFF -> SETTLE (pg stable) -> RESET (shifter on, node in reset)
// -> RUN -> DRAIN (wait for link idle or timeout) -> OFF.
// All outputs come from flops loaded with the decode of the next state,
// so no input reaches an output combinationally.
module bsg_fsb_node_ls_ctrl
  import bsg_fsb_node_ls_ctrl_pkg::*;
#(
  parameter int settle_cycles_p = 8,
  parameter int reset_cycles_p  = 4,
  parameter int drain_idle_p    = 4,
  parameter int drain_timeout_p = 64
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   up_req_i,
  input  logic                   down_req_i,
  bsg_fsb_node_ls_ctrl_if.master link,
  output logic                   on_o,
  output logic                   timeout_o,
  output logic                   fault_o,
  output logic [2:0]             state_o
);

  // SETTLE and RESET never overlap, so they share one counter sized for the larger.
  localparam int CntMax = (settle_cycles_p > reset_cycles_p) ? settle_cycles_p : reset_cycles_p;
  localparam int CntW   = counter_width(CntMax);
  localparam int IdleW  = counter_width(drain_idle_p);
  localparam int ToW    = counter_width(drain_timeout_p);

  localparam logic [CntW-1:0]  SettleLast = CntW'(settle_cycles_p - 1);
  localparam logic [CntW-1:0]  ResetLast  = CntW'(reset_cycles_p - 1);
  localparam logic [IdleW-1:0] IdleLast   = IdleW'(drain_idle_p - 1);
  localparam logic [ToW-1:0]   ToLast     = ToW'(drain_timeout_p - 1);

  ls_state_e state_q, state_d;
  ls_out_s   out_q, out_d;
  logic      fault_q, fault_d;
  logic      timeout_q, timeout_d;

  logic [CntW-1:0]  cnt;
  logic [IdleW-1:0] idle_cnt;
  logic [ToW-1:0]   to_cnt;
  logic             cnt_clr, cnt_up;
  logic             idle_clr, idle_up;
  logic             to_clr, to_up;
  logic             traffic;

  assign traffic = link.fsb_v_i | link.node_v_i;

  bsg_counter_clear_up #(.max_val_p(CntMax)) u_main_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (cnt_clr),
    .up_i    (cnt_up),
    .count_o (cnt)
  );

  bsg_counter_clear_up #(.max_val_p(drain_idle_p)) u_idle_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (idle_clr),
    .up_i    (idle_up),
    .count_o (idle_cnt)
  );

  bsg_counter_clear_up #(.max_val_p(drain_timeout_p)) u_to_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (to_clr),
    .up_i    (to_up),
    .count_o (to_cnt)
  );

  // Next-state and counter control. Counters default to cleared so every
  // state that does not own a counter keeps it at zero, and each state entry
  // starts from a clean count. pg loss with the shifter enabled is checked
  // first in RESET/RUN/DRAIN because it must override any request.
  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    timeout_d = 1'b0;
    cnt_clr   = 1'b1;
    cnt_up    = 1'b0;
    idle_clr  = 1'b1;
    idle_up   = 1'b0;
    to_clr    = 1'b1;
    to_up     = 1'b0;

    unique case (state_q)
      ST_OFF: begin
        if (up_req_i && link.pg_i) begin
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        cnt_clr = 1'b0;
        if (down_req_i && !up_req_i) begin
          state_d = ST_OFF;
          cnt_clr = 1'b1;
        end else if (!link.pg_i) begin
          cnt_clr = 1'b1;
        end else if (cnt == SettleLast) begin
          state_d = ST_RESET;
          cnt_clr = 1'b1;
        end else begin
          cnt_up = 1'b1;
        end
      end

      ST_RESET: begin
        cnt_clr = 1'b0;
        if (!link.pg_i) begin
          state_d = ST_OFF;
          fault_d = 1'b1;
          cnt_clr = 1'b1;
        end else if (cnt == ResetLast) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
        end else begin
          cnt_up = 1'b1;
        end
      end

      ST_RUN: begin
        if (!link.pg_i) begin
          state_d = ST_OFF;
          fault_d = 1'b1;
        end else if (down_req_i) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        idle_clr = 1'b0;
        to_clr   = 1'b0;
        if (!link.pg_i) begin
          state_d  = ST_OFF;
          fault_d  = 1'b1;
          idle_clr = 1'b1;
          to_clr   = 1'b1;
        end else if (!traffic && (idle_cnt == IdleLast)) begin
          state_d  = ST_OFF;
          idle_clr = 1'b1;
          to_clr   = 1'b1;
        end else if (to_cnt == ToLast) begin
          state_d   = ST_OFF;
          timeout_d = 1'b1;
          idle_clr  = 1'b1;
          to_clr    = 1'b1;
        end else begin
          to_up = 1'b1;
          if (traffic) begin
            idle_clr = 1'b1;
          end else begin
            idle_up = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  assign out_d = decode_outputs(state_d);

  // State plus registered outputs. Reset lands directly in the OFF levels
  // without passing through DRAIN, and is the only way to clear fault.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_OFF;
      out_q     <= decode_outputs(ST_OFF);
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      fault_q   <= fault_d;
      timeout_q <= timeout_d;
    end
  end

  assign link.en_ls_o      = out_q.en_ls;
  assign link.node_reset_o = out_q.node_reset;
  assign link.quiesce_o    = out_q.quiesce;
  assign on_o              = out_q.on;
  assign timeout_o         = timeout_q;
  assign fault_o           = fault_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_bsg_fsb_node_ls_ctrl.sv
// Directed bench for bsg_fsb_node_ls_ctrl with default parameters
// (settle 8, reset 4, drain idle 4, drain timeout 64).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_bsg_fsb_node_ls_ctrl;

  logic       clk;
  logic       reset;
  logic       upReq;
  logic       downReq;
  logic       onObs;
  logic       timeoutObs;
  logic       faultObs;
  logic [2:0] stateObs;

  int testsRun  = 0;
  int failCount = 0;

  bsg_fsb_node_ls_ctrl_if link ();

  bsg_fsb_node_ls_ctrl dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .up_req_i   (upReq),
    .down_req_i (downReq),
    .link       (link),
    .on_o       (onObs),
    .timeout_o  (timeoutObs),
    .fault_o    (faultObs),
    .state_o    (stateObs)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic pg, input logic up, input logic down,
                               input logic fsbV, input logic nodeV);
    link.pg_i     = pg;
    upReq         = up;
    downReq       = down;
    link.fsb_v_i  = fsbV;
    link.node_v_i = nodeV;
  endtask

  // Expected levels per state, hand-written from the output table:
  // {en_ls, node_reset, quiesce, on, timeout, fault, state[2:0]}.
  task automatic checkOutput(input string tag, input logic [2:0] st,
                             input logic expTimeout, input logic expFault);
    logic [3:0] lv;
    logic [8:0] expv;
    logic [8:0] obs;
    case (st)
      3'd0:    lv = 4'b0110;
      3'd1:    lv = 4'b0110;
      3'd2:    lv = 4'b1110;
      3'd3:    lv = 4'b1001;
      3'd4:    lv = 4'b1010;
      default: lv = 4'bxxxx;
    endcase
    expv = {lv, expTimeout, expFault, st};
    obs  = {link.en_ls_o, link.node_reset_o, link.quiesce_o, onObs,
            timeoutObs, faultObs, stateObs};
    testsRun++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b required=%b", tag, obs, expv);
    end
  endtask

  task automatic checkCountersZero(input string tag);
    logic [13:0] obs;
    obs = {dut.u_main_cnt.count_o, dut.u_idle_cnt.count_o, dut.u_to_cnt.count_o};
    testsRun++;
    assert (obs === 14'd0) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h required=0", tag, obs);
    end
  endtask

  // Cycle 0 samples up_req; RUN is reached at cycle 13.
  task automatic powerUp(input string tag, input logic expFault);
    applyStimulus(1, 1, 0, 0, 0);
    tick(1);
    applyStimulus(1, 0, 0, 0, 0);
    tick(12);
    checkOutput(tag, 3'd3, 0, expFault);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);

    // Reset state.
    tick(1);
    checkOutput("reset_state", 3'd0, 0, 0);
    checkCountersZero("reset_counters");
    tick(1);
    reset = 1'b0;

    // down_req alone in OFF is ignored.
    applyStimulus(1, 0, 1, 0, 0);
    tick(2);
    checkOutput("off_ignores_down", 3'd0, 0, 0);

    // Power-up latency.
    applyStimulus(1, 1, 0, 0, 0);
    tick(1);
    checkOutput("pu_c1_settle", 3'd1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    tick(7);
    checkOutput("pu_c8_settle", 3'd1, 0, 0);
    tick(1);
    checkOutput("pu_c9_en_ls", 3'd2, 0, 0);
    tick(3);
    checkOutput("pu_c12_reset", 3'd2, 0, 0);
    tick(1);
    checkOutput("pu_c13_run", 3'd3, 0, 0);

    // up_req in RUN is ignored.
    applyStimulus(1, 1, 0, 0, 0);
    tick(1);
    checkOutput("run_ignores_up", 3'd3, 0, 0);

    // Idle drain: OFF 4 cycles after DRAIN entry, no timeout.
    applyStimulus(1, 0, 1, 0, 0);
    tick(1);
    checkOutput("drain_entry", 3'd4, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    tick(3);
    checkOutput("drain_idle_e3", 3'd4, 0, 0);
    tick(1);
    checkOutput("drain_idle_off", 3'd0, 0, 0);

    // pg glitch at SETTLE cycle 5 restarts the settle count.
    applyStimulus(1, 1, 0, 0, 0);
    tick(1);
    applyStimulus(1, 0, 0, 0, 0);
    tick(4);
    applyStimulus(0, 0, 0, 0, 0);
    tick(1);
    checkOutput("glitch_c6_settle", 3'd1, 0, 0);
    checkCountersZero("glitch_cnt_cleared");
    applyStimulus(1, 0, 0, 0, 0);
    tick(7);
    checkOutput("glitch_c13_settle", 3'd1, 0, 0);
    tick(1);
    checkOutput("glitch_c14_en_ls", 3'd2, 0, 0);
    tick(4);
    checkOutput("glitch_c18_run", 3'd3, 0, 0);

    // Timeout drain: traffic every 3rd cycle keeps idle short of 4.
    applyStimulus(1, 0, 1, 0, 0);
    tick(1);
    checkOutput("to_drain_entry", 3'd4, 0, 0);
    for (int k = 0; k < 64; k++) begin
      applyStimulus(1, 0, 0, (k % 3) == 0, 0);
      if (k == 62) checkOutput("to_drain_e62", 3'd4, 0, 0);
      tick(1);
    end
    checkOutput("to_off_pulse", 3'd0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    tick(1);
    checkOutput("to_pulse_one_cycle", 3'd0, 0, 0);
    for (int k = 65; k < 100; k++) begin
      applyStimulus(1, 0, 0, (k % 3) == 0, 0);
      tick(1);
    end
    checkOutput("to_stays_off", 3'd0, 0, 0);

    // pg lost in RUN: fault is sticky through a new power-up until reset.
    powerUp("fault_pu_run", 0);
    applyStimulus(0, 0, 0, 0, 0);
    tick(1);
    checkOutput("fault_run_pg_loss", 3'd0, 0, 1);
    powerUp("fault_sticky_run", 1);
    reset = 1'b1;
    tick(1);
    checkOutput("fault_cleared_by_reset", 3'd0, 0, 0);
    reset = 1'b0;

    // Reset during RESET.
    applyStimulus(1, 1, 0, 0, 0);
    tick(1);
    applyStimulus(1, 0, 0, 0, 0);
    tick(9);
    checkOutput("rst_in_reset_pre", 3'd2, 0, 0);
    reset = 1'b1;
    tick(1);
    checkOutput("rst_in_reset_off", 3'd0, 0, 0);
    checkCountersZero("rst_in_reset_cnt");
    reset = 1'b0;

    // Reset during DRAIN with traffic in flight.
    powerUp("rst_drain_pu", 0);
    applyStimulus(1, 0, 1, 0, 0);
    tick(1);
    applyStimulus(1, 0, 0, 1, 1);
    tick(2);
    checkOutput("rst_in_drain_pre", 3'd4, 0, 0);
    reset = 1'b1;
    tick(1);
    checkOutput("rst_in_drain_off", 3'd0, 0, 0);
    checkCountersZero("rst_in_drain_cnt");
    reset = 1'b0;

    // up & down together in OFF act as up; down alone in SETTLE returns to OFF.
    applyStimulus(1, 1, 1, 0, 0);
    tick(1);
    checkOutput("up_down_off_settle", 3'd1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    tick(1);
    checkOutput("settle_down_off", 3'd0, 0, 0);

    // pg lost in RESET.
    applyStimulus(1, 1, 0, 0, 0);
    tick(1);
    applyStimulus(1, 0, 0, 0, 0);
    tick(8);
    applyStimulus(0, 0, 0, 0, 0);
    tick(1);
    checkOutput("reset_pg_loss", 3'd0, 0, 1);
    reset = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    tick(1);
    reset = 1'b0;

    // pg lost in DRAIN.
    powerUp("drain_pg_pu", 0);
    applyStimulus(1, 0, 1, 0, 0);
    tick(1);
    applyStimulus(0, 0, 0, 0, 0);
    tick(1);
    checkOutput("drain_pg_loss", 3'd0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/bsg_fsb_node_ls_ctrl.md
Name: bsg_fsb_node_ls_ctrl

Overview:
- Power-up and power-down sequencer for one FSB node behind its level-shift/isolation wrapper.
- Drives the wrapper's isolation enable (en_ls) and the node-side reset.
- Monitors link traffic so the node is only isolated after the FSB link has quiesced.
- Sits in the always-on FSB domain, one instance per switchable node.

Parameters:
- settle_cycles_p, 8: consecutive cycles pg_i must stay high before isolation is released.
- reset_cycles_p, 4: cycles node_reset_o is held high with en_ls_o=1 before RUN.
- drain_idle_p, 4: consecutive traffic-free cycles required in DRAIN before isolating.
- drain_timeout_p, 64: maximum cycles spent in DRAIN before forced isolation.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- pg_i  in  1  node power-good, already synchronized.
- up_req_i  in  1  level request: power the node up.
- down_req_i  in  1  level request: power the node down.
- fsb_v_i  in  1  node->FSB valid, observed after the shifter.
- node_v_i  in  1  FSB->node valid, observed after the shifter.
- en_ls_o  out  1  level-shifter enable; 0 = isolated.
- node_reset_o  out  1  reset to the node domain.
- quiesce_o  out  1  tells the node and FSB to stop issuing new packets.
- on_o  out  1  high only in RUN.
- timeout_o  out  1  one-cycle pulse when DRAIN is forcibly ended.
- fault_o  out  1  sticky; pg_i lost while en_ls_o=1.
- state_o  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset: one clock; reset_i is synchronous and active-high. In the cycle after reset_i is sampled high:
  - state=OFF, all counters=0.
  - en_ls_o=0, node_reset_o=1, quiesce_o=1, on_o=0, timeout_o=0, fault_o=0.
  - Reset asserted mid-sequence (any state) returns to OFF the same way; no drain is performed.
- Outputs are registered or decoded from the state register only; there is no combinational path from any input to any output.
- FSM encodings: OFF=0, SETTLE=1, RESET=2, RUN=3, DRAIN=4.
- OFF: en_ls_o=0, node_reset_o=1, quiesce_o=1.
  - up_req_i & pg_i -> SETTLE, with cnt cleared.
  - down_req_i is ignored.
  - up_req_i & down_req_i together: treated as up.
- SETTLE: en_ls_o=0, node_reset_o=1.
  - cnt increments each cycle pg_i=1 and clears on pg_i=0 (the count restarts).
  - cnt reaches settle_cycles_p-1 with pg_i=1 -> RESET, cnt cleared.
  - down_req_i (without up_req_i) -> OFF.
- RESET: en_ls_o=1, node_reset_o=1, quiesce_o=1.
  - Lasts exactly reset_cycles_p cycles, then -> RUN.
  - pg_i=0 -> OFF and fault_o set.
- RUN: en_ls_o=1, node_reset_o=0, quiesce_o=0, on_o=1.
  - down_req_i -> DRAIN, with idle_cnt and to_cnt cleared; up_req_i is ignored.
  - pg_i=0 -> OFF immediately and fault_o set; this takes priority over down_req_i.
- DRAIN: en_ls_o=1, node_reset_o=0, quiesce_o=1.
  - idle_cnt increments on cycles with fsb_v_i|node_v_i = 0 and clears on any activity.
  - to_cnt increments every cycle.
  - idle_cnt reaches drain_idle_p-1 on an idle cycle -> OFF.
  - Otherwise, to_cnt reaches drain_timeout_p-1 -> OFF with timeout_o pulsed in the cycle OFF is entered. Idle completion wins a same-cycle tie.
  - up_req_i in DRAIN is ignored; a new power-up needs a fresh request from OFF.
  - pg_i=0 -> OFF and fault_o set.
- fault_o clears only on reset_i.
- Latency: with up_req_i sampled at cycle 0 and pg_i held high:
  - SETTLE in cycles 1..S, RESET in cycles S+1..S+R, RUN at cycle S+R+1.
  - en_ls_o rises at cycle S+1; node_reset_o falls at cycle S+R+1.
  - Defaults: en_ls_o at cycle 9, RUN at cycle 13.
- Counter widths: ceil(log2(max parameter + 1)); counters never wrap.
- Every parameter must be >= 1; a value of 1 means a single-cycle stay in that state.

Decomposition:
- Package bsg_fsb_node_ls_ctrl_pkg holds the state enum (3-bit) and the encodings listed above.
- One sub-module: bsg_counter_clear_up, a clear/enable up-counter.
  - Instantiated for the settle/reset counter, idle_cnt and to_cnt.
  - Width is derived from the max count.

Test Plan:
- Power-up, pg_i=1, up_req_i one cycle at t0 -> en_ls_o=1 at t0+9, node_reset_o=0 and on_o=1 at t0+13, state_o=3.
- pg_i glitch low for 1 cycle at SETTLE cycle 5 -> counter restarts; en_ls_o rises 8 cycles after pg_i returns high.
- Idle drain: from RUN, down_req_i with no traffic -> state_o=4 next cycle; OFF (en_ls_o=0, node_reset_o=1) 4 cycles later; timeout_o stays 0.
- Drain with fsb_v_i toggling every 3rd cycle for 100 cycles -> OFF exactly 64 cycles after DRAIN entry with a one-cycle timeout_o pulse.
- pg_i drops in RUN -> next cycle OFF, en_ls_o=0, fault_o=1; fault_o stays 1 through a new power-up until reset_i.
- reset_i asserted during RESET and during DRAIN -> next cycle OFF, en_ls_o=0, node_reset_o=1, all counters 0; simultaneous up_req_i & down_req_i in OFF -> enters SETTLE.
